// File: rtl/instr_mem_loader.sv
// Streams program bytes into 32-bit instruction words and writes them to instruction memory.
// The CPU is held in reset until a load ends on a zero terminator word.
module instr_mem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
  output logic          byte_ready_o,
  output logic          im_we_o,
  output logic [AW-1:0] im_addr_o,
  output logic [31:0]   im_wdata_o,
  output logic          cpu_rst_n_o,
  output logic          load_done_o,
  output logic          load_err_o,
  output logic [AW:0]   word_cnt_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0] state;
  logic [1:0] byte_idx;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      byte_ready_o <= 1'b0;
      im_we_o      <= 1'b0;
      im_addr_o    <= '0;
      im_wdata_o   <= '0;
      cpu_rst_n_o  <= 1'b0;
      load_done_o  <= 1'b0;
      load_err_o   <= 1'b0;
      word_cnt_o   <= '0;
    end else begin
      im_we_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state        <= RECV;
            byte_ready_o <= 1'b1;
            byte_idx     <= 2'd0;
            im_addr_o    <= '0;
            word_cnt_o   <= '0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
            cpu_rst_n_o  <= 1'b0;
          end
        end
        RECV: begin
          // Bytes land directly in the write-data register, little-endian.
          if (byte_valid_i && byte_ready_o) begin
            im_wdata_o[{byte_idx, 3'b000} +: 8] <= byte_i;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state        <= WRITE;
              byte_ready_o <= 1'b0;
              im_we_o      <= 1'b1;
              word_cnt_o   <= word_cnt_o + 1'b1;
            end
          end
        end
        WRITE: begin
          if (im_wdata_o == 32'd0) begin
            state       <= DONE;
            load_done_o <= 1'b1;
            cpu_rst_n_o <= 1'b1;
          end else if (im_addr_o == LAST_ADDR) begin
            // Memory full with no terminator: stop rather than wrap.
            state       <= DONE;
            load_done_o <= 1'b1;
            load_err_o  <= 1'b1;
          end else begin
            state        <= RECV;
            im_addr_o    <= im_addr_o + 1'b1;
            byte_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
